// File: rtl/stopwatch_pkg.sv
// Shared stopwatch display constants and types.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package stopwatch_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int MAX_MIN    = 99;
    localparam int MAX_SEC    = 59;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DIG [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef enum logic {ON, OFF} blink_phase_e;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} conv_state_e;

    // Non-decimal values fall back to a blank digit.
    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0:    s = SEG_DIG[0];
            4'd1:    s = SEG_DIG[1];
            4'd2:    s = SEG_DIG[2];
            4'd3:    s = SEG_DIG[3];
            4'd4:    s = SEG_DIG[4];
            4'd5:    s = SEG_DIG[5];
            4'd6:    s = SEG_DIG[6];
            4'd7:    s = SEG_DIG[7];
            4'd8:    s = SEG_DIG[8];
            4'd9:    s = SEG_DIG[9];
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_time_display_if.sv
// Time-in / display-out bundle of the seven-segment driver.
// min/sec/blink flow master->slave; seg/an (active-low) flow back.
interface sevenseg_time_display_if;

    logic [6:0] min;
    logic [5:0] sec;
    logic       blink;
    logic [7:0] seg;
    logic [3:0] an;

    modport master (output min, sec, blink, input seg, an);
    modport slave  (input min, sec, blink, output seg, an);

endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter, one bit per cycle.
// Ports: clk, rst, start, value in; busy, done (last shift), tens, ones out.
module bin2bcd_seq
    import stopwatch_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    localparam int CW = $clog2(WIDTH + 1);

    // {tens, ones, binary}; the loaded value doubles as the snapshot.
    logic [WIDTH+7:0] sr;
    logic [CW-1:0]    iter;
    logic [7:0]       adj;

    always_comb begin
        adj = sr[WIDTH+7:WIDTH];
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    end

    // done is high during the cycle whose edge performs the final shift.
    assign done = busy && (iter == CW'(WIDTH - 1));
    assign tens = sr[WIDTH+7:WIDTH+4];
    assign ones = sr[WIDTH+3:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= '0;
            iter <= '0;
            busy <= 1'b0;
        end else if (busy) begin
            sr   <= {adj, sr[WIDTH-1:0]} << 1;
            iter <= iter + 1'b1;
            if (done) busy <= 1'b0;
        end else if (start) begin
            sr   <= {8'd0, value};
            iter <= '0;
            busy <= 1'b1;
        end
    end

endmodule

// File: rtl/sevenseg_time_display.sv
// MM.SS driver for a 4-digit common-anode multiplexed display.
// Ports: clk, rst (sync, active-high), bus (slave: min, sec, blink in; seg, an out).
// Build option SEVENSEG_LEAD_ZERO_BLANK_EN blanks a leading minutes-tens zero.
module sevenseg_time_display
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input logic                     clk,
    input logic                     rst,
    sevenseg_time_display_if.slave  bus
);

    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DW = $clog2(NUM_DIGITS);

    logic [SW-1:0] scan_cnt;
    logic          scan_tick;
    logic [DW-1:0] digit_idx;
    logic [BW-1:0] blink_cnt;
    blink_phase_e  blink_phase;
    logic          init_cap;
    conv_state_e   state, state_nx;
    logic          cap_req, cap_go, load;
    logic [6:0]    min_c, sec_c;
    logic [3:0]    disp [NUM_DIGITS];
    logic          m_busy, m_done, s_busy, s_done;
    logic [3:0]    m_tens, m_ones, s_tens, s_ones;
    logic [3:0]    an_d;
    logic [7:0]    seg_d;

    assign scan_tick = (scan_cnt == SW'(SCAN_DIV - 1));

    assign min_c = (bus.min > 7'(MAX_MIN)) ? 7'(MAX_MIN) : bus.min;
    assign sec_c = {1'b0, (bus.sec > 6'(MAX_SEC)) ? 6'(MAX_SEC) : bus.sec};

    // Snapshot at frame wrap so a whole frame shows one consistent time.
    assign cap_req = init_cap || (scan_tick && digit_idx == DW'(NUM_DIGITS - 1));
    assign cap_go  = cap_req && (state == IDLE) && !m_busy && !s_busy;

    bin2bcd_seq #(.WIDTH(7)) u_min (
        .clk   (clk),
        .rst   (rst),
        .start (cap_go),
        .value (min_c),
        .busy  (m_busy),
        .done  (m_done),
        .tens  (m_tens),
        .ones  (m_ones)
    );

    // Seconds run at the same width so both fields finish together.
    bin2bcd_seq #(.WIDTH(7)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .start (cap_go),
        .value (sec_c),
        .busy  (s_busy),
        .done  (s_done),
        .tens  (s_tens),
        .ones  (s_ones)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            IDLE: if (cap_go) state_nx = CONV;
            CONV: if (m_done && s_done) state_nx = LOAD;
            LOAD: begin
                load     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        an_d  = ~(4'b0001 << digit_idx);
        seg_d = seg_of(disp[digit_idx]);
        if (digit_idx == DW'(2)) seg_d[7] = 1'b0;
`ifdef SEVENSEG_LEAD_ZERO_BLANK_EN
        if (digit_idx == DW'(3) && disp[3] == 4'd0) seg_d = SEG_BLANK;
`endif
        if (bus.blink && blink_phase == OFF) an_d = 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt    <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            blink_phase <= ON;
            init_cap    <= 1'b1;
            state       <= IDLE;
            for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= '0;
            bus.an      <= 4'b1111;
            bus.seg     <= SEG_BLANK;
        end else begin
            if (scan_tick) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 1'b1;
            end else begin
                scan_cnt  <= scan_cnt + 1'b1;
            end
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= (blink_phase == ON) ? OFF : ON;
            end else begin
                blink_cnt   <= blink_cnt + 1'b1;
            end
            init_cap <= 1'b0;
            state    <= state_nx;
            if (load) begin
                disp[0] <= s_ones;
                disp[1] <= s_tens;
                disp[2] <= m_ones;
                disp[3] <= m_tens;
            end
            bus.an  <= an_d;
            bus.seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_sevenseg_time_display.sv
// Scoreboard bench for sevenseg_time_display (SCAN_DIV=16, BLINK_DIV=16).
// Expected an/seg are queued per cycle; a monitor pops and compares.
module tb_sevenseg_time_display;
    import stopwatch_pkg::*;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] seg;
        bit         chk_seg;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    int   e0, e1;
    exp_t q[$];
    exp_t hd;
    logic [7:0] lead;

    sevenseg_time_display_if dif();

    sevenseg_time_display #(
        .CLK_HZ   (64),
        .SCAN_HZ  (4),
        .BLINK_HZ (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void want(int c, logic [3:0] a, logic [7:0] s,
                                 bit cs, string t);
        exp_t e;
        e.cyc = c;
        e.an = a;
        e.seg = s;
        e.chk_seg = cs;
        e.tag = t;
        q.push_back(e);
    endfunction

    task automatic at_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            hd = q.pop_front();
            n_run++;
            if (hd.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d missed at %0d",
                         hd.tag, hd.cyc, cyc);
            end else if (dif.an !== hd.an ||
                         (hd.chk_seg && dif.seg !== hd.seg)) begin
                n_fail++;
                $display("FAIL %s @%0d: an=%b seg=%h, want an=%b seg=%h",
                         hd.tag, cyc, dif.an, dif.seg, hd.an, hd.seg);
            end
        end
    end

    initial begin
`ifdef SEVENSEG_LEAD_ZERO_BLANK_EN
        lead = SEG_BLANK;
`else
        lead = SEG_DIG[0];
`endif
        rst = 1'b1;
        dif.min = 7'd12;
        dif.sec = 6'd34;
        dif.blink = 1'b0;

        // Reset held over edges 1..3, then 12:34.
        at_cyc(1);
        want(2, 4'b1111, 8'hFF, 1, "rst_a");
        want(3, 4'b1111, 8'hFF, 1, "rst_b");
        at_cyc(3);
        e0 = cyc;
        rst = 1'b0;
        want(e0 + 1,  4'b1110, SEG_DIG[0], 1, "pre_conv");
        want(e0 + 9,  4'b1110, SEG_DIG[0], 1, "lat_edge");
        want(e0 + 10, 4'b1110, SEG_DIG[4], 1, "d0_4");
        want(e0 + 16, 4'b1110, SEG_DIG[4], 1, "d0_end");
        want(e0 + 17, 4'b1101, SEG_DIG[3], 1, "d1_3");
        want(e0 + 33, 4'b1011, SEG_DIG[2] & 8'h7F, 1, "d2_2dp");
        want(e0 + 49, 4'b0111, SEG_DIG[1], 1, "d3_1");

        // Clamp: 127:63 shows 99.59 from the next frame.
        at_cyc(e0 + 60);
        dif.min = 7'd127;
        dif.sec = 6'd63;
        want(e0 + 72,  4'b1110, SEG_DIG[4], 1, "old_hold");
        want(e0 + 73,  4'b1110, SEG_DIG[9], 1, "clamp_s1");
        want(e0 + 80,  4'b1110, SEG_DIG[9], 1, "clamp_s1b");
        want(e0 + 81,  4'b1101, SEG_DIG[5], 1, "clamp_s10");
        want(e0 + 97,  4'b1011, SEG_DIG[9] & 8'h7F, 1, "clamp_m1");
        want(e0 + 113, 4'b0111, SEG_DIG[9], 1, "clamp_m10");

        // Tear-free: 12:59, seconds drop to 0 mid-frame.
        at_cyc(e0 + 100);
        dif.min = 7'd12;
        dif.sec = 6'd59;
        want(e0 + 137, 4'b1110, SEG_DIG[9], 1, "tf_s1");
        at_cyc(e0 + 150);
        dif.sec = 6'd0;
        want(e0 + 160, 4'b1101, SEG_DIG[5], 1, "tf_s10_hold");
        want(e0 + 161, 4'b1011, SEG_DIG[2] & 8'h7F, 1, "tf_m1");
        want(e0 + 177, 4'b0111, SEG_DIG[1], 1, "tf_m10");
        want(e0 + 200, 4'b1110, SEG_DIG[9], 1, "tf_pre_load");
        want(e0 + 201, 4'b1110, SEG_DIG[0], 1, "tf_new_s1");
        want(e0 + 209, 4'b1101, SEG_DIG[0], 1, "tf_new_s10");

        // Blink: off windows are cycles e0+241..256 and e0+273..288.
        at_cyc(e0 + 230);
        dif.blink = 1'b1;
        want(e0 + 240, 4'b1011, SEG_DIG[2] & 8'h7F, 1, "bl_on_end");
        want(e0 + 241, 4'b1111, 8'h00, 0, "bl_off_start");
        want(e0 + 256, 4'b1111, 8'h00, 0, "bl_off_end");
        want(e0 + 257, 4'b1110, SEG_DIG[0], 1, "bl_on2");
        want(e0 + 272, 4'b1110, SEG_DIG[0], 1, "bl_on2_end");
        want(e0 + 273, 4'b1111, 8'h00, 0, "bl_off2");
        want(e0 + 280, 4'b1111, 8'h00, 0, "bl_off2_mid");
        at_cyc(e0 + 280);
        dif.blink = 1'b0;
        want(e0 + 281, 4'b1101, SEG_DIG[0], 1, "bl_release");

        // Reset three cycles after the capture at edge e0+320.
        at_cyc(e0 + 300);
        dif.min = 7'd45;
        dif.sec = 6'd6;
        at_cyc(e0 + 322);
        rst = 1'b1;
        want(e0 + 323, 4'b1111, 8'hFF, 1, "mid_rst_a");
        want(e0 + 325, 4'b1111, 8'hFF, 1, "mid_rst_b");
        at_cyc(e0 + 325);
        e1 = cyc;
        rst = 1'b0;
        dif.min = 7'd7;
        dif.sec = 6'd8;
        want(e1 + 1,  4'b1110, SEG_DIG[0], 1, "abort_clear");
        want(e1 + 10, 4'b1110, SEG_DIG[8], 1, "re_s1");
        want(e1 + 17, 4'b1101, SEG_DIG[0], 1, "re_s10");
        want(e1 + 33, 4'b1011, SEG_DIG[7] & 8'h7F, 1, "re_m1");
        want(e1 + 49, 4'b0111, lead, 1, "re_m10");

        // 05:30 leading digit.
        at_cyc(e1 + 50);
        dif.min = 7'd5;
        dif.sec = 6'd30;
        want(e1 + 72,  4'b1110, SEG_DIG[8], 1, "lz_old");
        want(e1 + 73,  4'b1110, SEG_DIG[0], 1, "lz_s1");
        want(e1 + 81,  4'b1101, SEG_DIG[3], 1, "lz_s10");
        want(e1 + 97,  4'b1011, SEG_DIG[5] & 8'h7F, 1, "lz_m1");
        want(e1 + 113, 4'b0111, lead, 1, "lz_m10");

        at_cyc(e1 + 120);
        if (q.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL drain: %0d checks left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
